// File: rtl/rshift_arbiter.sv
// Two-requester round-robin burst arbiter; each accepted beat is arithmetically
// right-shifted per element and presented on a single-entry output register.
module rshift_arbiter #(
  parameter int unsigned WIDTH_OUT = 16,
  parameter int unsigned ELEMS     = 8,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned SHIFT_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  input  logic                         in0_valid,
  input  logic                         in1_valid,
  output logic                         in0_ready,
  output logic                         in1_ready,
  input  logic [WIDTH_OUT*ELEMS-1:0]   in0_data,
  input  logic [WIDTH_OUT*ELEMS-1:0]   in1_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_OUT*ELEMS-1:0]   out_data,
  output logic                         out_src,
  output logic                         out_last,
  output logic                         busy
);

  localparam int unsigned DATA_W = WIDTH_OUT * ELEMS;
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                prio_q, prio_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_src_q, out_src_d;
  logic                out_last_q, out_last_d;

  logic                drain_ok_c;
  logic                sel_valid_c;
  logic                accept_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic [DATA_W-1:0]   shifted_c;
  logic [WIDTH_OUT-1:0] elem_c;

  // The output register can take a new beat when empty or draining this cycle.
  assign drain_ok_c  = !out_valid_q || out_ready;
  assign sel_valid_c = grant_q ? in1_valid : in0_valid;
  assign accept_c    = (state_q == BURST) && sel_valid_c && drain_ok_c;

  assign in0_ready = (state_q == BURST) && !grant_q && drain_ok_c;
  assign in1_ready = (state_q == BURST) &&  grant_q && drain_ok_c;

  // Per-element sign-filling shift; oversize shifts saturate to the sign bit.
  always_comb begin
    sel_data_c = grant_q ? in1_data : in0_data;
    shifted_c  = '0;
    elem_c     = '0;
    for (int i = 0; i < int'(ELEMS); i++) begin
      elem_c = sel_data_c[i*WIDTH_OUT +: WIDTH_OUT];
      if (32'(shift_q) >= WIDTH_OUT) begin
        shifted_c[i*WIDTH_OUT +: WIDTH_OUT] = {WIDTH_OUT{elem_c[WIDTH_OUT-1]}};
      end else begin
        shifted_c[i*WIDTH_OUT +: WIDTH_OUT] = WIDTH_OUT'($signed(elem_c) >>> shift_q);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (in0_valid || in1_valid) begin
          grant_d = (in0_valid && in1_valid) ? prio_q : in1_valid;
          shift_d = cfg_shift;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept_c) begin
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
            prio_d  = !grant_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept reloads the register even while draining, so there is no bubble.
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_data_d  = shifted_c;
      out_src_d   = grant_q;
      out_last_d  = (cnt_q == LAST_CNT);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_rshift_arbiter.sv
// Directed bench for rshift_arbiter: shift results, round-robin order,
// back-pressure hold, config latching and mid-burst reset.
module tb_rshift_arbiter;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    cfg_shift;
  logic          in0_valid, in1_valid;
  logic          in0_ready, in1_ready;
  logic [DW-1:0] in0_data, in1_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_src, out_last, busy;

  int n_checks = 0;
  int n_errors = 0;

  rshift_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_shift (cfg_shift),
    .in0_valid (in0_valid),
    .in1_valid (in1_valid),
    .in0_ready (in0_ready),
    .in1_ready (in1_ready),
    .in0_data  (in0_data),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] mixed_in, mixed_exp;
    logic [3:0]    src_seq;
    int            nb;

    mixed_in  = {16'h8000, 16'h7FFF, {6{16'h0100}}};
    mixed_exp = {16'hFFFF, 16'h0000, {6{16'h0000}}};

    rst_n = 1'b0; cfg_shift = '0; in0_valid = 0; in1_valid = 0;
    in0_data = '0; in1_data = '0; out_ready = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    rst_n = 1'b1;

    // Single requester, shift 4
    cfg_shift = 5'd4; in0_data = rep(16'h0100); in0_valid = 1;
    check("idle_in0_ready", in0_ready, 0);
    tick();
    check("grant_busy", busy, 1);
    check("grant_in0_ready", in0_ready, 1);
    check("grant_in1_ready", in1_ready, 0);
    tick();
    check("b0_valid", out_valid, 1);
    check("b0_data", out_data, rep(16'h0010));
    check("b0_src", out_src, 0);
    check("b0_last", out_last, 0);
    in0_data = rep(16'hFF00);
    tick();
    check("b1_data", out_data, rep(16'hFFF0));
    check("b1_last", out_last, 1);
    check("b1_busy", busy, 0);
    in0_valid = 0;
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_busy", busy, 0);

    // Round robin from a fresh priority pointer
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    cfg_shift = 5'd0; in0_data = rep(16'h0111); in1_data = rep(16'h0222);
    in0_valid = 1; in1_valid = 1;
    nb = 0; src_seq = '0;
    for (int c = 0; c < 40 && nb < 4; c++) begin
      tick();
      if (out_valid) begin
        check("rr_data", out_data, out_src ? rep(16'h0222) : rep(16'h0111));
        if (out_last) begin
          src_seq[3-nb] = out_src;
          nb++;
        end
      end
    end
    in0_valid = 0; in1_valid = 0;
    check("rr_bursts", nb, 4);
    check("rr_order", src_seq, 4'b0101);
    tick();

    // Back-pressure for 3 cycles mid-burst, then drain+accept together
    in0_data = rep(16'h0AAA); in0_valid = 1;
    tick();
    tick();
    check("bp_b0", out_data, rep(16'h0AAA));
    out_ready = 0; in0_data = rep(16'h0BBB);
    #1;
    check("bp_in0_ready", in0_ready, 0);
    check("bp_in1_ready", in1_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_data", out_data, rep(16'h0AAA));
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_last", out_last, 0);
      check("bp_hold_ready", in0_ready, 0);
    end
    out_ready = 1;
    #1;
    check("bp_release_ready", in0_ready, 1);
    tick();
    check("bp_b1_valid", out_valid, 1);
    check("bp_b1_data", out_data, rep(16'h0BBB));
    check("bp_b1_last", out_last, 1);
    in0_valid = 0;
    tick();
    check("bp_drain", out_valid, 0);

    // Oversize shift saturates to sign bits
    cfg_shift = 5'd31; in1_data = mixed_in; in1_valid = 1;
    tick();
    tick();
    check("sh31_mixed", out_data, mixed_exp);
    check("sh31_src", out_src, 1);
    in1_data = rep(16'h8000);
    tick();
    check("sh31_neg", out_data, rep(16'hFFFF));
    check("sh31_last", out_last, 1);
    in1_valid = 0;
    tick();

    // cfg_shift change mid-burst is ignored
    cfg_shift = 5'd4; in0_data = rep(16'h0100); in0_valid = 1;
    tick();
    cfg_shift = 5'd2;
    tick();
    check("cfg_b0", out_data, rep(16'h0010));
    tick();
    check("cfg_b1", out_data, rep(16'h0010));
    in0_valid = 0;
    tick();

    // Mid-burst reset: pointer is 1 here, reset must restore it to 0
    cfg_shift = 5'd0; in0_data = rep(16'h1234); in1_data = rep(16'h5678);
    in0_valid = 1; in1_valid = 1;
    tick();
    tick();
    check("mr_pre_src", out_src, 1);
    check("mr_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_data", out_data, 0);
    check("mr_src", out_src, 0);
    check("mr_busy", busy, 0);
    check("mr_in1_ready", in1_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mr_post_src", out_src, 0);
    check("mr_post_data", out_data, rep(16'h1234));
    in0_valid = 0; in1_valid = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
